// File: rtl/st_seq_pkg.sv
// Shared constants, state encoding and helpers for the MIX store sequencer.
package st_seq_pkg;

   localparam int unsigned OPC_W    = 6;
   localparam int unsigned FIELD_W  = 6;
   localparam int unsigned WORD_W   = 31;
   localparam int unsigned SEL_W    = 4;
   localparam int unsigned BYTE_W   = 6;
   localparam int unsigned SIGN_BIT = 30;

   // Store opcodes (C field)
   localparam logic [OPC_W-1:0] OP_STA = 6'd24;
   localparam logic [OPC_W-1:0] OP_ST1 = 6'd25;
   localparam logic [OPC_W-1:0] OP_ST2 = 6'd26;
   localparam logic [OPC_W-1:0] OP_ST3 = 6'd27;
   localparam logic [OPC_W-1:0] OP_ST4 = 6'd28;
   localparam logic [OPC_W-1:0] OP_ST5 = 6'd29;
   localparam logic [OPC_W-1:0] OP_ST6 = 6'd30;
   localparam logic [OPC_W-1:0] OP_STX = 6'd31;
   localparam logic [OPC_W-1:0] OP_STJ = 6'd32;
   localparam logic [OPC_W-1:0] OP_STZ = 6'd33;

   // Register file read selects
   localparam logic [SEL_W-1:0] SEL_A  = 4'd0;
   localparam logic [SEL_W-1:0] SEL_I1 = 4'd1;
   localparam logic [SEL_W-1:0] SEL_X  = 4'd7;
   localparam logic [SEL_W-1:0] SEL_J  = 4'd8;

   // (0:5) covers the whole word, so no read-modify-write is needed
   localparam logic [FIELD_W-1:0] F_FULL = 6'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_REGRD,
      S_MEMRD,
      S_MERGE,
      S_MWAIT,
      S_MEMWR,
      S_DONE
   } state_e;

   // F = 8*L + R is usable when L <= R <= 5
   function automatic logic valid_field(input logic [FIELD_W-1:0] f);
      return (f[5:3] <= f[2:0]) && (f[2:0] <= 3'd5);
   endfunction

   // Source register for a (range-checked) store opcode; STZ reads nothing useful
   function automatic logic [SEL_W-1:0] sel_of(input logic [OPC_W-1:0] op);
      logic [SEL_W-1:0] sel;
      sel = SEL_A;
      case (op)
         OP_STA:                   sel = SEL_A;
         OP_ST1, OP_ST2, OP_ST3,
         OP_ST4, OP_ST5, OP_ST6:   sel = SEL_I1 + SEL_W'(op - OP_ST1);
         OP_STX:                   sel = SEL_X;
         OP_STJ:                   sel = SEL_J;
         default:                  sel = SEL_A;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/st_src_fmt.sv
// Combinational formatting of the value to be stored (STZ zero, STJ address part only).
module st_src_fmt
   import st_seq_pkg::*;
(
   input  logic [OPC_W-1:0]  opcode_i,
   input  logic [WORD_W-1:0] reg_data_i,
   output logic [WORD_W-1:0] value_c_o
);

   // Select the stored word according to the opcode
   always_comb begin
      value_c_o = reg_data_i;
      if (opcode_i == OP_STZ) begin
         value_c_o = '0;
      end else if (opcode_i == OP_STJ) begin
         // rJ holds a two-byte positive address: sign +, bytes 1-3 cleared
         value_c_o = '0;
         value_c_o[2*BYTE_W-1:0] = reg_data_i[2*BYTE_W-1:0];
         value_c_o[SIGN_BIT] = 1'b0;
      end
   end

endmodule

// File: rtl/st_seq.sv
// MIX store sequencer: validates a store, reads the source register and performs
// read-modify-write through the external field-merge unit.
module st_seq
   import st_seq_pkg::*;
#(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned MEM_WORDS = 4000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [OPC_W-1:0]    opcode,
   input  logic [FIELD_W-1:0]  field,
   input  logic [ADDR_W-1:0]   addressin,
   output logic                stop,
   output logic                fault,
   output logic                busy,
   output logic [SEL_W-1:0]    reg_sel,
   input  logic [WORD_W-1:0]   reg_data,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic [WORD_W-1:0]   mem_wdata,
   input  logic [WORD_W-1:0]   mem_rdata,
   input  logic                mem_ack,
   output logic                merge_start,
   output logic [FIELD_W-1:0]  merge_field,
   output logic [WORD_W-1:0]   merge_in,
   output logic [WORD_W-1:0]   merge_data,
   input  logic                merge_stop,
   input  logic [WORD_W-1:0]   merge_out
);

   state_e              state_q;
   logic [OPC_W-1:0]    opcode_q;
   logic [FIELD_W-1:0]  field_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                stop_q;
   logic                fault_q;
   logic                busy_q;
   logic [SEL_W-1:0]    reg_sel_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                mem_rd_q;
   logic                mem_wr_q;
   logic [WORD_W-1:0]   mem_wdata_q;
   logic                merge_start_q;
   logic [FIELD_W-1:0]  merge_field_q;
   logic [WORD_W-1:0]   merge_in_q;
   logic [WORD_W-1:0]   merge_data_q;

   logic [WORD_W-1:0]   new_val_c;
   logic                bad_req_c;

   st_src_fmt u_src_fmt (
      .opcode_i   (opcode_q),
      .reg_data_i (reg_data),
      .value_c_o  (new_val_c)
   );

   // Any of these conditions aborts the store before touching memory
   always_comb begin
      bad_req_c = 1'b0;
      if ((opcode_q < OP_STA) || (opcode_q > OP_STZ)) bad_req_c = 1'b1;
      if (!valid_field(field_q))                       bad_req_c = 1'b1;
      if (32'(addr_q) >= MEM_WORDS)                    bad_req_c = 1'b1;
   end

   // Sequencer state and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         opcode_q      <= '0;
         field_q       <= '0;
         addr_q        <= '0;
         stop_q        <= 1'b0;
         fault_q       <= 1'b0;
         busy_q        <= 1'b0;
         reg_sel_q     <= '0;
         mem_addr_q    <= '0;
         mem_rd_q      <= 1'b0;
         mem_wr_q      <= 1'b0;
         mem_wdata_q   <= '0;
         merge_start_q <= 1'b0;
         merge_field_q <= '0;
         merge_in_q    <= '0;
         merge_data_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !busy_q) begin
                  opcode_q <= opcode;
                  field_q  <= field;
                  addr_q   <= addressin;
                  busy_q   <= 1'b1;
                  state_q  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (bad_req_c) begin
                  stop_q  <= 1'b1;
                  fault_q <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  reg_sel_q  <= sel_of(opcode_q);
                  mem_addr_q <= addr_q;
                  state_q    <= S_REGRD;
               end
            end
            S_REGRD: begin
               if (field_q == F_FULL) begin
                  mem_wdata_q <= new_val_c;
                  mem_wr_q    <= 1'b1;
                  state_q     <= S_MEMWR;
               end else begin
                  merge_in_q    <= new_val_c;
                  merge_field_q <= field_q;
                  mem_rd_q      <= 1'b1;
                  state_q       <= S_MEMRD;
               end
            end
            S_MEMRD: begin
               if (mem_ack) begin
                  merge_data_q  <= mem_rdata;
                  mem_rd_q      <= 1'b0;
                  merge_start_q <= 1'b1;
                  state_q       <= S_MERGE;
               end
            end
            S_MERGE: begin
               merge_start_q <= 1'b0;
               state_q       <= S_MWAIT;
            end
            S_MWAIT: begin
               if (merge_stop) begin
                  mem_wdata_q <= merge_out;
                  mem_wr_q    <= 1'b1;
                  state_q     <= S_MEMWR;
               end
            end
            S_MEMWR: begin
               if (mem_ack) begin
                  mem_wr_q <= 1'b0;
                  stop_q   <= 1'b1;
                  fault_q  <= 1'b0;
                  state_q  <= S_DONE;
               end
            end
            S_DONE: begin
               stop_q  <= 1'b0;
               fault_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign stop        = stop_q;
   assign fault       = fault_q;
   assign busy        = busy_q;
   assign reg_sel     = reg_sel_q;
   assign mem_addr    = mem_addr_q;
   assign mem_rd      = mem_rd_q;
   assign mem_wr      = mem_wr_q;
   assign mem_wdata   = mem_wdata_q;
   assign merge_start = merge_start_q;
   assign merge_field = merge_field_q;
   assign merge_in    = merge_in_q;
   assign merge_data  = merge_data_q;

endmodule
